// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the normaliser state type.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [31:0] NINF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } state_t;

endpackage

// File: rtl/fp_result_pack.sv
// Combinational packer: sign/exponent/fraction plus class flags into an IEEE-754 single.
module fp_result_pack
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [MANT_W-1:0] frac,
    input  logic              is_exc,
    input  logic              is_zero,
    input  logic              is_ovf,
    input  logic              is_unf,
    output logic [31:0]       result
);

    // Exceptional classes override the raw fields; zero is always +0.
    always_comb begin
        result = {sign, exp, frac};
        if (is_exc) begin
            result = QNAN;
        end else if (is_zero) begin
            result = 32'h0000_0000;
        end else if (is_ovf) begin
            result = {sign, EXP_MAX, {MANT_W{1'b0}}};
        end else if (is_unf) begin
            result = {sign, {EXP_W{1'b0}}, frac};
        end
    end

endmodule

// File: rtl/fp_addsub_norm_seq.sv
// Iterative normalise/pack stage behind the FP32 add/sub datapath.
// One left shift per NORM cycle; truncation rounding; results held in OUT until taken.
module fp_addsub_norm_seq
    import fp32_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W+1:0] in_mant,
    input  logic              in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_exception,
    output logic [4:0]        out_shift
);

    localparam logic [EXP_W:0] EXP_ONE = 1;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic [MANT_W+1:0]   mant_q, mant_d;
    logic                exc_q, exc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_result_q, out_result_d;
    logic                out_overflow_q, out_overflow_d;
    logic                out_underflow_q, out_underflow_d;
    logic                out_exception_q, out_exception_d;
    logic [4:0]          out_shift_q, out_shift_d;

    logic [EXP_W:0]      sh_exp;
    logic [EXP_W-1:0]    pk_exp;
    logic [MANT_W-1:0]   pk_frac;
    logic                pk_exc, pk_zero, pk_ovf, pk_unf, done;
    logic [31:0]         pk_result;

    fp_result_pack u_pack (
        .sign    (sign_q),
        .exp     (pk_exp),
        .frac    (pk_frac),
        .is_exc  (pk_exc),
        .is_zero (pk_zero),
        .is_ovf  (pk_ovf),
        .is_unf  (pk_unf),
        .result  (pk_result)
    );

    // Next-state: capture in IDLE, one normalisation rule per NORM cycle, hold in OUT.
    always_comb begin
        state_d         = state_q;
        sign_d          = sign_q;
        exp_d           = exp_q;
        mant_d          = mant_q;
        exc_d           = exc_q;
        cnt_d           = cnt_q;
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_overflow_d  = out_overflow_q;
        out_underflow_d = out_underflow_q;
        out_exception_d = out_exception_q;
        out_shift_d     = out_shift_q;
        sh_exp          = exp_q + EXP_ONE;
        pk_exp          = exp_q[EXP_W-1:0];
        pk_frac         = mant_q[MANT_W-1:0];
        pk_exc          = 1'b0;
        pk_zero         = 1'b0;
        pk_ovf          = 1'b0;
        pk_unf          = 1'b0;
        done            = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {1'b0, in_exp};
                    mant_d  = in_mant;
                    exc_d   = in_exc;
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (exc_q) begin
                    pk_exc = 1'b1;
                    done   = 1'b1;
                end else if (mant_q == '0) begin
                    pk_zero = 1'b1;
                    done    = 1'b1;
                end else if (mant_q[MANT_W+1]) begin
                    // Carry-out: renormalise right, truncating the dropped LSB.
                    pk_exp  = sh_exp[EXP_W-1:0];
                    pk_frac = mant_q[MANT_W:1];
                    pk_ovf  = (sh_exp >= {1'b0, EXP_MAX});
                    done    = 1'b1;
                end else if (mant_q[MANT_W]) begin
                    done = 1'b1;
                end else if (exp_q <= EXP_ONE) begin
                    pk_unf = 1'b1;
                    done   = 1'b1;
                end else begin
                    mant_d = {mant_q[MANT_W:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                    cnt_d  = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
                end
                if (done) begin
                    state_d         = OUT;
                    out_valid_d     = 1'b1;
                    out_result_d    = pk_result;
                    out_overflow_d  = pk_ovf;
                    out_underflow_d = pk_unf;
                    out_exception_d = pk_exc;
                    out_shift_d     = cnt_q;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            sign_q          <= 1'b0;
            exp_q           <= '0;
            mant_q          <= '0;
            exc_q           <= 1'b0;
            cnt_q           <= 5'd0;
            out_valid_q     <= 1'b0;
            out_result_q    <= 32'h0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_exception_q <= 1'b0;
            out_shift_q     <= 5'd0;
        end else begin
            state_q         <= state_d;
            sign_q          <= sign_d;
            exp_q           <= exp_d;
            mant_q          <= mant_d;
            exc_q           <= exc_d;
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_overflow_q  <= out_overflow_d;
            out_underflow_q <= out_underflow_d;
            out_exception_q <= out_exception_d;
            out_shift_q     <= out_shift_d;
        end
    end

    assign in_ready      = (state_q == IDLE) && !rst;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_overflow  = out_overflow_q;
    assign out_underflow = out_underflow_q;
    assign out_exception = out_exception_q;
    assign out_shift     = out_shift_q;

endmodule
